// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM states and the
// priority encoder that picks the next stage to apply.
package shift_sequencer_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int SHAMT_W     = 5;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic logic [2:0] msb_index(input logic [SHAMT_W-1:0] v);
    logic [2:0] k;
    if (v[4])      k = 3'd4;
    else if (v[3]) k = 3'd3;
    else if (v[2]) k = 3'd2;
    else if (v[1]) k = 3'd1;
    else           k = 3'd0;
    return k;
  endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// One fixed power-of-two shift stage (1/2/4/8/16 selected by sel) for
// left-logical, right-logical and right-arithmetic shifts.
module shift_sequencer_stage
  import shift_sequencer_pkg::*;
(
  input  logic [SHIFT_WIDTH-1:0] in_word,
  input  logic [2:0]             sel,
  input  logic [1:0]             op,
  output logic [SHIFT_WIDTH-1:0] out_word
);

  logic [SHIFT_WIDTH-1:0] w_sll;
  logic [SHIFT_WIDTH-1:0] w_srl;
  logic [SHIFT_WIDTH-1:0] w_sra;
  logic                   w_sign;

  assign w_sign = in_word[SHIFT_WIDTH-1];

  always_comb begin
    w_sll = in_word;
    w_srl = in_word;
    w_sra = in_word;
    case (sel)
      3'd0: begin
        w_sll = {in_word[30:0], 1'b0};
        w_srl = {1'b0, in_word[31:1]};
        w_sra = {w_sign, in_word[31:1]};
      end
      3'd1: begin
        w_sll = {in_word[29:0], 2'b0};
        w_srl = {2'b0, in_word[31:2]};
        w_sra = {{2{w_sign}}, in_word[31:2]};
      end
      3'd2: begin
        w_sll = {in_word[27:0], 4'b0};
        w_srl = {4'b0, in_word[31:4]};
        w_sra = {{4{w_sign}}, in_word[31:4]};
      end
      3'd3: begin
        w_sll = {in_word[23:0], 8'b0};
        w_srl = {8'b0, in_word[31:8]};
        w_sra = {{8{w_sign}}, in_word[31:8]};
      end
      3'd4: begin
        w_sll = {in_word[15:0], 16'b0};
        w_srl = {16'b0, in_word[31:16]};
        w_sra = {{16{w_sign}}, in_word[31:16]};
      end
      default: begin
        w_sll = in_word;
        w_srl = in_word;
        w_sra = in_word;
      end
    endcase
  end

  // The reserved op code falls through to the left shift.
  always_comb begin
    case (op)
      SHIFT_OP_SRL: out_word = w_srl;
      SHIFT_OP_SRA: out_word = w_sra;
      default:      out_word = w_sll;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies the 16/8/4/2/1 stages one per cycle, skipping
// stages whose amount bit is clear. in_valid/in_ready and out_valid/out_ready
// transfer when both are high on a rising clock edge.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [4:0]       r_rem;
  logic [1:0]       r_op;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [2:0]       w_k;
  logic [4:0]       w_rem_next;
  logic [WIDTH-1:0] w_stage_out;

  assign w_k        = msb_index(r_rem);
  assign w_rem_next = r_rem & ~(5'd1 << w_k);

  shift_sequencer_stage u_stage (
    .in_word  (r_acc),
    .sel      (w_k),
    .op       (r_op),
    .out_word (w_stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_op        <= SHIFT_OP_SLL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc      <= in_data;
            r_rem      <= in_shamt;
            r_op       <= in_op;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (in_shamt == 5'd0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_stage_out;
          r_rem <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: driver pushes expected results and
// latencies into queues, a monitor compares them as results are presented.
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          acc_cyc;
  logic        prev_ov;

  shift_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // monitor / scoreboard
  initial begin
    prev_ov = 1'b0;
    acc_cyc = 0;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - acc_cyc + 1), 32'(lat_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", out_data, 32'hxxxx_xxxx);
        else chk("out_data", out_data, exp_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_shamt = shamt;
    in_op    = op;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom_range(0, 31));
    in_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt,
                      input logic [31:0] exp, input int lat);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    issue(op, data, shamt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_data"},  out_data,           32'd0);
    chk({tag, "_state"},     {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int n;
    n_chk     = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step();

    send(2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 2);
    send(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6);
    send(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 6);
    send(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    send(2'b11, 32'h0000_0003, 5'd3,  32'h0000_0018, 3);
    send(2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 2);
    send(2'b01, 32'h1234_5678, 5'd12, 32'h0001_2345, 3);
    send(2'b00, 32'h1234_5678, 5'd20, 32'h6780_0000, 3);
    wait_idle();

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000, 2);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 32'hAAAA_0000 + 32'(i);
      in_shamt = 5'd1;
      step();
      chk("bp_out_data", out_data, 32'h0F00_0000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_state_idle", {30'd0, dbg_state}, 32'd0);
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // reset mid-shift: the aborted request must never produce a result
    issue(2'b00, 32'h0000_0001, 5'd31);
    step();
    step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) chk("abort_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort_idle", {31'd0, in_ready}, 32'd1);
    send(2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 3);
    wait_idle();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("lat_queue_empty", 32'(lat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
